// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: key-schedule FSM states, schedule constants and
// key-byte selection.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_I  = 3'd1,
    CALC_J  = 3'd2,
    READ_J  = 3'd3,
    LATCH_J = 3'd4,
    WRITE_I = 3'd5,
    WRITE_J = 3'd6
  } ksa_state_e;

  localparam int KEY_BYTES       = 3;
  localparam int CYCLES_PER_ITER = 6;

  // k0 is the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    logic [7:0] kb;
    case (idx)
      2'd0:    kb = key[23:16];
      2'd1:    kb = key[15:8];
      2'd2:    kb = key[7:0];
      default: kb = 8'd0;
    endcase
    return kb;
  endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key schedule over an external 256x8 S memory with 1-cycle read latency.
// Six cycles per byte: read S[i], update j, read S[j], latch, write both.
module ksa
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  ksa_state_e  state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic        wren_q, wren_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    kidx_d   = kidx_q;
    key_d    = key_q;
    si_d     = si_q;
    sj_d     = sj_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && rdy_q) begin
          key_d   = key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
          state_d = READ_I;
        end
      end
      READ_I:  state_d = CALC_J;
      CALC_J: begin
        si_d    = rddata;
        j_d     = 8'(j_q + rddata + key_byte(key_q, kidx_q));
        state_d = READ_J;
      end
      READ_J:  state_d = LATCH_J;
      LATCH_J: begin
        sj_d    = rddata;
        state_d = WRITE_I;
      end
      WRITE_I: state_d = WRITE_J;
      WRITE_J: begin
        if (i_q == 8'd255) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_d = READ_I;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory-facing outputs are registered, so derive them from the next state.
    case (state_d)
      READ_I:  addr_d = i_d;
      READ_J:  addr_d = j_d;
      WRITE_I: begin
        addr_d   = i_d;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
      end
      WRITE_J: begin
        addr_d   = j_d;
        wrdata_d = si_d;
        wren_d   = 1'b1;
      end
      default: begin
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
      end
    endcase

    // rdy returns one cycle after the last write, once the FSM has settled in IDLE.
    rdy_d = (state_d == IDLE) && (state_q == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      kidx_q   <= 2'd0;
      key_q    <= 24'd0;
      si_q     <= 8'd0;
      sj_q     <= 8'd0;
      rdy_q    <= 1'b1;
      addr_q   <= 8'd0;
      wrdata_q <= 8'd0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kidx_q   <= kidx_d;
      key_q    <= key_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      rdy_q    <= rdy_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign rdy    = rdy_q;
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: behavioural S memory, write-log table checks,
// full-schedule reference model and reset/re-start corner sequences.
module tb_ksa;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  ksa dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  logic [7:0] log_a [16];
  logic [7:0] log_d [16];
  int         log_n;
  logic       log_clr;
  always @(negedge clk) begin
    if (log_clr) begin
      log_n <= 0;
    end else if (wren && log_n < 16) begin
      log_a[log_n] <= addr;
      log_d[log_n] <= wrdata;
      log_n <= log_n + 1;
    end
  end

  typedef struct {
    logic [23:0] key;
    int          idx;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;
  vec_t vecs[12];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc0  = 0;
  int edges = 0;
  int diffs = 0;
  logic [7:0] ref_s [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic prep();
    mem_init = 1'b1;
    log_clr  = 1'b1;
    tick();
    mem_init = 1'b0;
    log_clr  = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] k);
    key = k;
    en  = 1'b1;
    tick();
    en   = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic wait_done();
    while (!rdy && (cyc - cyc0) < 3000) tick();
    edges = cyc - cyc0;
  endtask

  function automatic void ref_ksa(input logic [23:0] k);
    logic [7:0] j, t, kb;
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      case (n % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + ref_s[n] + kb;
      t = ref_s[n];
      ref_s[n] = ref_s[j];
      ref_s[j] = t;
    end
  endfunction

  task automatic cmp_model(input string name);
    diffs = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== ref_s[n]) diffs++;
    chk(name, diffs, 0);
  endtask

  task automatic check_log(input logic [23:0] k);
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].key == k) begin
        chk($sformatf("wr%0d_addr_k%0h", vecs[v].idx, k), log_a[vecs[v].idx], vecs[v].exp_addr);
        chk($sformatf("wr%0d_data_k%0h", vecs[v].idx, k), log_d[vecs[v].idx], vecs[v].exp_data);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{24'h000000, 0, 8'd0, 8'd0};
    vecs[1]  = '{24'h000000, 1, 8'd0, 8'd0};
    vecs[2]  = '{24'h000000, 2, 8'd1, 8'd1};
    vecs[3]  = '{24'h000000, 3, 8'd1, 8'd1};
    vecs[4]  = '{24'h000000, 4, 8'd2, 8'd3};
    vecs[5]  = '{24'h000000, 5, 8'd3, 8'd2};
    vecs[6]  = '{24'h000001, 0, 8'd0, 8'd0};
    vecs[7]  = '{24'h000001, 1, 8'd0, 8'd0};
    vecs[8]  = '{24'h000001, 2, 8'd1, 8'd1};
    vecs[9]  = '{24'h000001, 3, 8'd1, 8'd1};
    vecs[10] = '{24'h000001, 4, 8'd2, 8'd4};
    vecs[11] = '{24'h000001, 5, 8'd4, 8'd2};

    rst = 1'b1; en = 1'b0; key = 24'd0; mem_init = 1'b1; log_clr = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", wren, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrdata", wrdata, 0);

    // Key 0: write sequence and full result
    prep();
    start_run(24'h000000);
    chk("k0_rdy_low", rdy, 0);
    wait_done();
    chk("k0_edges", edges, 1537);
    check_log(24'h000000);
    ref_ksa(24'h000000);
    cmp_model("k0_final");

    // Key 1: stop after three iterations via reset
    prep();
    start_run(24'h000001);
    repeat (18) tick();
    chk("k1_s0", mem[0], 0);
    chk("k1_s1", mem[1], 1);
    chk("k1_s2", mem[2], 4);
    chk("k1_s4", mem[4], 2);
    check_log(24'h000001);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Key 00033C: full-length timing and model
    prep();
    start_run(24'h00033C);
    wait_done();
    chk("k33c_edges", edges, 1537);
    ref_ksa(24'h00033C);
    cmp_model("k33c_final");
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("k33c_wren_after%0d", n), wren, 0);
      tick();
    end

    // Reset at cycle 100 with en also high; reset wins, then clean restart
    prep();
    start_run(24'h00033C);
    repeat (99) tick();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    chk("abort_rdy", rdy, 1);
    chk("abort_wren", wren, 0);
    chk("abort_addr", addr, 0);
    tick();
    chk("abort_idle", rdy, 1);
    prep();
    start_run(24'h00033C);
    wait_done();
    chk("restart_edges", edges, 1537);
    cmp_model("restart_final");

    // en pulse and key change mid-run are ignored; held en restarts after rdy
    prep();
    start_run(24'h123456);
    repeat (49) tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (200) tick();
    key = 24'hABCDEF;
    en  = 1'b1;
    wait_done();
    chk("ign_edges", edges, 1537);
    ref_ksa(24'h123456);
    cmp_model("ign_final");
    tick();
    chk("held_en_restart", rdy, 0);
    en  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ksa.md
KSA -- requirements
Module: ksa

Interface
REQ-001 The block SHALL use exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 en  input  1  start request; sampled only on an edge where rdy=1.
REQ-005 rdy  output  1  high = idle and able to accept en.
REQ-006 key  input  24  cipher key; byte k0=key[23:16], k1=key[15:8], k2=key[7:0].
REQ-007 addr  output  8  S-memory address.
REQ-008 rddata  input  8  S-memory read data, valid the cycle after addr is presented (1-cycle latency).
REQ-009 wrdata  output  8  S-memory write data.
REQ-010 wren  output  1  S-memory write enable.

Function
REQ-011 The block SHALL perform the ARC4 key schedule on the 256-byte S memory left by the init block: j=0; for i=0..255: j=(j+S[i]+k[i mod 3]) mod 256; swap S[i],S[j].
REQ-012 States SHALL be IDLE, READ_I, CALC_J, READ_J, LATCH_J, WRITE_I, WRITE_J.
REQ-013 IDLE: rdy=1, wren=0; en=1 at an edge SHALL latch key, clear i and j, and go to READ_I; rdy=0 from the next cycle.
REQ-014 READ_I: addr=i, wren=0 -> CALC_J.
REQ-015 CALC_J: latch si=rddata; j<=(j+rddata+kbyte) mod 256, 8-bit wrap with carries discarded -> READ_J.
REQ-016 READ_J: addr=j, wren=0 -> LATCH_J.
REQ-017 LATCH_J: latch sj=rddata -> WRITE_I.
REQ-018 WRITE_I: addr=i, wrdata=sj, wren=1 -> WRITE_J.
REQ-019 WRITE_J: addr=j, wrdata=si, wren=1; if i=255 -> IDLE, else i<=i+1 and mod-3 key index advances (2->0) -> READ_I.
REQ-020 Each iteration SHALL take exactly 6 cycles; rdy SHALL reassert 1537 edges after the accepting edge.
REQ-021 i=j SHALL write the unchanged value twice, leaving S[i] intact.
REQ-022 wren SHALL be high only in WRITE_I and WRITE_J and low in every other cycle, including after completion.
REQ-023 en while rdy=0 SHALL be ignored; en held high through completion SHALL start a new run on the first edge with rdy=1.
REQ-024 key changes during a run SHALL have no effect; the key latched at start is used.

Reset
REQ-025 An edge with rst=1 SHALL force IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, key index=0, regardless of state.
REQ-026 Reset mid-run SHALL abort without further writes; partial S contents are not restored.
REQ-027 rst SHALL take priority over en on the same edge.

Structure
REQ-028 The state enum and constants KEY_BYTES=3, CYCLES_PER_ITER=6 SHALL live in shared package arc4_pkg.
REQ-029 No sub-module is warranted: the mod-3 key-byte index is a 2-bit counter inside ksa; S memory is the existing external 256x8 RAM.

Verification
REQ-030 Identity S, key=24'h000000, start -> first wren cycles: (addr 0, data 0), (0, 0), (1, 1), (1, 1), (2, 3), (3, 2); after the third iteration S[2]=3, S[3]=2.
REQ-031 Identity S, key=24'h000001 -> third iteration uses j=4; after it S[2]=4, S[4]=2, S[0..1] unchanged.
REQ-032 Identity S, key=24'h00033C -> rdy reasserts exactly 1537 edges after the start edge; final S matches a bench reference model byte-for-byte; wren=0 for 3 cycles after.
REQ-033 rst pulsed at cycle 100 of a run -> next cycle rdy=1, wren=0, addr=0; a new en restarts from i=0, j=0.
REQ-034 en pulsed at cycle 50 of a run, and key changed mid-run -> no restart, completion still at edge 1537, result equals the original-key model.
